// File: rtl/pwm2bin_32bit.sv
// PWM-to-binary decoder: recovers four 8-bit samples per 32-bit word from a
// slot-aligned PWM stream (256 clocks per slot) and presents them over a valid/ready handshake.
module pwm2bin_32bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aud_en,
    input  logic        pwm_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        sync_err_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        CAPTURE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [SYNC_STAGES-1:0] r_syncChain;
    logic                   r_pwmD;
    logic                   w_pwmS;
    logic                   w_rise;

    logic [7:0]  r_slotPos;
    logic [7:0]  w_nextSlotPos;
    logic [8:0]  r_highCount;
    logic [8:0]  w_nextHighCount;
    logic [1:0]  r_slotIdx;
    logic [1:0]  w_nextSlotIdx;
    logic [23:0] r_partial;
    logic [23:0] w_nextPartial;

    logic [8:0] w_total;
    logic [7:0] w_sample;
    logic       w_syncErr;
    logic       w_wordDone;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_syncChain <= '0;
            r_pwmD      <= 1'b0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], pwm_i};
            r_pwmD      <= w_pwmS;
        end
    end

    assign w_pwmS   = r_syncChain[SYNC_STAGES-1];
    assign w_rise   = w_pwmS && !r_pwmD;
    // Slot total is 1..256; 256 wraps to 0 in [7:0] so total-1 lands on 8'hFF.
    assign w_total  = r_highCount + {8'd0, w_pwmS};
    assign w_sample = w_total[7:0] - 8'd1;

    always_comb begin
        w_nextState     = r_state;
        w_nextSlotPos   = r_slotPos;
        w_nextHighCount = r_highCount;
        w_nextSlotIdx   = r_slotIdx;
        w_nextPartial   = r_partial;
        w_syncErr       = 1'b0;
        w_wordDone      = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextSlotPos   = 8'd0;
                w_nextHighCount = 9'd0;
                w_nextSlotIdx   = 2'd0;
                w_nextPartial   = 24'd0;
                if (aud_en) begin
                    w_nextState = HUNT;
                end
            end

            HUNT: begin
                if (w_rise) begin
                    w_nextState     = CAPTURE;
                    w_nextSlotPos   = 8'd1;
                    w_nextHighCount = 9'd1;
                    w_nextSlotIdx   = 2'd0;
                    w_nextPartial   = 24'd0;
                end
            end

            CAPTURE: begin
                if (w_rise && (r_slotPos != 8'd0)) begin
                    // An edge mid-slot means we were misaligned: restart the word on this edge.
                    w_syncErr       = 1'b1;
                    w_nextSlotPos   = 8'd1;
                    w_nextHighCount = 9'd1;
                    w_nextSlotIdx   = 2'd0;
                    w_nextPartial   = 24'd0;
                end else if (r_slotPos == 8'hFF) begin
                    w_nextSlotPos   = 8'd0;
                    w_nextHighCount = 9'd0;
                    if (w_total == 9'd0) begin
                        w_syncErr     = 1'b1;
                        w_nextState   = HUNT;
                        w_nextSlotIdx = 2'd0;
                        w_nextPartial = 24'd0;
                    end else begin
                        w_nextSlotIdx = r_slotIdx + 2'd1;
                        case (r_slotIdx)
                            2'd0: w_nextPartial[23:16] = w_sample;
                            2'd1: w_nextPartial[15:8]  = w_sample;
                            2'd2: w_nextPartial[7:0]   = w_sample;
                            default: begin
                                w_wordDone    = 1'b1;
                                w_nextPartial = 24'd0;
                            end
                        endcase
                    end
                end else begin
                    w_nextSlotPos   = r_slotPos + 8'd1;
                    w_nextHighCount = r_highCount + {8'd0, w_pwmS};
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (!aud_en) begin
            w_nextState     = IDLE;
            w_nextSlotPos   = 8'd0;
            w_nextHighCount = 9'd0;
            w_nextSlotIdx   = 2'd0;
            w_nextPartial   = 24'd0;
            w_syncErr       = 1'b0;
            w_wordDone      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_slotPos   <= 8'd0;
            r_highCount <= 9'd0;
            r_slotIdx   <= 2'd0;
            r_partial   <= 24'd0;
        end else begin
            r_state     <= w_nextState;
            r_slotPos   <= w_nextSlotPos;
            r_highCount <= w_nextHighCount;
            r_slotIdx   <= w_nextSlotIdx;
            r_partial   <= w_nextPartial;
        end
    end

    // A completed word only replaces data_o if the previous one is gone or leaving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o     <= 32'h0;
            valid_o    <= 1'b0;
            sync_err_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            sync_err_o <= w_syncErr;
            if (!aud_en) begin
                valid_o   <= 1'b0;
                overrun_o <= 1'b0;
            end else if (w_wordDone) begin
                if (!valid_o || ready_i) begin
                    data_o  <= {r_partial, w_sample};
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm2bin_32bit.sv
// Bench for pwm2bin_32bit: encodes known sample bytes as PWM slots and checks the
// words, error pulses and flags the decoder reports against the bytes that were sent.
module tb_pwm2bin_32bit;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        aud_en;
    logic        pwm_i;
    logic        ready_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        sync_err_o;
    logic        overrun_o;

    int compareCount = 0;
    int failCount    = 0;
    int errCount     = 0;
    int errBase      = 0;
    int cycleCount   = 0;
    int startCycle   = 0;
    int riseCycle    = 0;
    bit markNext     = 1'b0;
    bit randomReady  = 1'b0;
    bit prevValid    = 1'b0;
    bit holdPending  = 1'b0;
    logic [31:0] heldData = 32'h0;
    logic [31:0] rxQ[$];
    logic [31:0] sentWords[$];

    pwm2bin_32bit #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .aud_en    (aud_en),
        .pwm_i     (pwm_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sync_err_o(sync_err_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Consumer side: collect accepted words, count error pulses, and insist a stalled word stays put.
    always @(negedge clk) begin
        if (rst) begin
            prevValid   = 1'b0;
            holdPending = 1'b0;
        end else begin
            if (holdPending && valid_o) checkOutput("holdData", data_o, heldData);
            holdPending = valid_o && !ready_i;
            heldData    = data_o;
            if (valid_o && ready_i) rxQ.push_back(data_o);
            if (sync_err_o) errCount++;
            if (valid_o && !prevValid) riseCycle = cycleCount;
            prevValid = valid_o;
        end
    end

    // Encoder: a slot carrying sample d is high for d+1 clocks from its start.
    task automatic applyStimulus(input logic [7:0] duty, input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            if (markNext) begin
                startCycle = cycleCount;
                markNext   = 1'b0;
            end
            pwm_i = (i <= int'(duty));
            if (randomReady) ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 0; k < 4; k++) applyStimulus(w[31-8*k -: 8], 256);
    endtask

    task automatic idleCycles(input int n);
        pwm_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        pwm_i  = 1'b0;
        aud_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        aud_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rxQ.delete();
        errBase = errCount;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] w1;

        rst     = 1'b1;
        aud_en  = 1'b0;
        pwm_i   = 1'b0;
        ready_i = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            pwm_i = ~pwm_i;
            aud_en = 1'b1;
        end
        checkOutput("rstData", data_o, 32'h0);
        checkOutput("rstValid", valid_o, 32'h0);
        checkOutput("rstSyncErr", sync_err_o, 32'h0);
        checkOutput("rstOverrun", overrun_o, 32'h0);
        rst = 1'b0;

        // Known word with the latency measured from the first pin edge.
        settle();
        ready_i  = 1'b1;
        markNext = 1'b1;
        sendWord(32'h007FFF10);
        idleCycles(8);
        checkOutput("basicCount", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("basicWord", rxQ[0], 32'h007FFF10);
        checkOutput("basicErr", errCount - errBase, 0);
        checkOutput("basicOverrun", overrun_o, 32'h0);
        checkOutput("latency", riseCycle - startCycle, SYNC + 1024);

        // Stalled consumer: first word held, second dropped.
        settle();
        ready_i = 1'b0;
        sendWord(32'h01020304);
        sendWord(32'hFEFDFCFB);
        idleCycles(8);
        checkOutput("ovrData", data_o, 32'h01020304);
        checkOutput("ovrValid", valid_o, 32'h1);
        checkOutput("ovrFlag", overrun_o, 32'h1);
        checkOutput("ovrErr", errCount - errBase, 0);
        checkOutput("ovrCount", rxQ.size(), 0);
        aud_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("disValid", valid_o, 32'h0);
        checkOutput("disOverrun", overrun_o, 32'h0);
        checkOutput("disData", data_o, 32'h01020304);

        // Disable mid-slot 1 of a second word while the first is still pending.
        settle();
        ready_i = 1'b0;
        w1 = $urandom;
        sendWord(w1);
        applyStimulus(8'($urandom), 256);
        applyStimulus(8'($urandom), 128);
        checkOutput("preDropValid", valid_o, 32'h1);
        aud_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("dropValid", valid_o, 32'h0);
        checkOutput("dropOverrun", overrun_o, 32'h0);
        checkOutput("dropData", data_o, w1);
        settle();
        ready_i = 1'b1;
        w = $urandom;
        sendWord(w);
        idleCycles(8);
        checkOutput("reenCount", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("reenWord", rxQ[0], w);
        checkOutput("reenErr", errCount - errBase, 0);

        // Stray edge at position 100 of slot 2 realigns the decoder.
        settle();
        ready_i = 1'b1;
        applyStimulus(8'($urandom), 256);
        applyStimulus(8'($urandom), 256);
        applyStimulus(8'($urandom_range(0, 80)), 100);
        w = $urandom;
        sendWord(w);
        idleCycles(8);
        checkOutput("realignErr", errCount - errBase, 1);
        checkOutput("realignCount", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("realignWord", rxQ[0], w);

        // Line goes quiet after lock: error at the first empty slot, then hunt again.
        settle();
        ready_i = 1'b1;
        applyStimulus(8'd9, 610);
        checkOutput("quietErr", errCount - errBase, 1);
        checkOutput("quietCount", rxQ.size(), 0);
        checkOutput("quietValid", valid_o, 32'h0);
        w = $urandom;
        sendWord(w);
        idleCycles(8);
        checkOutput("relockCount", rxQ.size(), 1);
        if (rxQ.size() > 0) checkOutput("relockWord", rxQ[0], w);
        checkOutput("relockErr", errCount - errBase, 1);

        // Reset in the middle of slot 3 discards the frame.
        settle();
        ready_i = 1'b1;
        w = {24'($urandom), 8'($urandom_range(0, 99))};
        for (int k = 0; k < 3; k++) applyStimulus(w[31-8*k -: 8], 256);
        applyStimulus(w[7:0], 128);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midRstData", data_o, 32'h0);
        checkOutput("midRstValid", valid_o, 32'h0);
        checkOutput("midRstSyncErr", sync_err_o, 32'h0);
        checkOutput("midRstOverrun", overrun_o, 32'h0);
        rst = 1'b0;
        idleCycles(400);
        checkOutput("midRstCount", rxQ.size(), 0);
        checkOutput("midRstValidLater", valid_o, 32'h0);

        // Random back-to-back words with a randomly stalling consumer.
        settle();
        sentWords.delete();
        randomReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            sentWords.push_back(w);
            sendWord(w);
        end
        randomReady = 1'b0;
        ready_i     = 1'b1;
        idleCycles(8);
        checkOutput("randCount", rxQ.size(), sentWords.size());
        for (int k = 0; k < sentWords.size(); k++) begin
            if (k < rxQ.size()) checkOutput($sformatf("randWord%0d", k), rxQ[k], sentWords[k]);
        end
        checkOutput("randErr", errCount - errBase, 0);
        checkOutput("randOverrun", overrun_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/pwm2bin_32bit.md
PWM2BIN_32BIT -- requirements
Module: pwm2bin_32bit

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on pwm_i (legal 2..4).
REQ-002 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port aud_en, input, 1: decoder enable; low forces IDLE.
REQ-005 SHALL have port pwm_i, input, 1: asynchronous PWM stream (256-clock slots, 4 slots per word).
REQ-006 SHALL have port data_o, output, 32: decoded word; slot 0 in [31:24], slot 1 in [23:16], slot 2 in [15:8], slot 3 in [7:0].
REQ-007 SHALL have port valid_o, output, 1: data_o holds an unconsumed word.
REQ-008 SHALL have port ready_i, input, 1: consumer accepts the word when valid_o&&ready_i.
REQ-009 SHALL have port sync_err_o, output, 1: one-cycle pulse on loss of slot alignment.
REQ-010 SHALL have port overrun_o, output, 1: sticky flag; a completed word was dropped.

Function
REQ-011 SHALL pass pwm_i through SYNC_STAGES flops to give pwm_s, plus one more flop to give pwm_d; rise = pwm_s && !pwm_d.
REQ-012 SHALL implement states IDLE, HUNT, CAPTURE with 8-bit slot position sc, 9-bit high count oc, and 2-bit slot index si.
REQ-013 IDLE: when aud_en=1, SHALL go to HUNT next cycle.
REQ-014 HUNT: on rise, SHALL enter CAPTURE with sc=1, oc=1, si=0; the rise cycle is defined as slot position 0.
REQ-015 CAPTURE, normal cycle (sc!=0 and no rise): SHALL apply sc+=1 (wrapping 255->0) and oc+=pwm_s.
REQ-016 CAPTURE at sc==255: SHALL compute total = oc+pwm_s (range 1..256); sample[7:0] = total-1; store sample in byte lane 3-si; then si+=1 and oc=0.
REQ-017 If total==0 at sc==255, SHALL pulse sync_err_o, discard the partial word, and go to HUNT.
REQ-018 Rise in CAPTURE at sc==0 SHALL be normal; pwm_s is counted as usual.
REQ-019 Rise in CAPTURE at sc!=0 SHALL pulse sync_err_o, discard the partial word, and realign immediately: sc=1, oc=1, si=0, staying in CAPTURE.
REQ-020 Level high across a slot boundary with no rise (previous sample 255) SHALL NOT be an error.
REQ-021 When the sample for si==3 is stored, the word SHALL be complete; data_o and valid_o SHALL update at the next clock edge.
REQ-022 On word completion with valid_o=0, or with valid_o=1 and ready_i=1 in the same cycle, SHALL load the new word and set valid_o=1.
REQ-023 On word completion with valid_o=1 and ready_i=0, SHALL drop the new word, hold data_o, and set overrun_o.
REQ-024 Handshake: when valid_o&&ready_i and no completion that cycle, SHALL clear valid_o next cycle; data_o SHALL be stable while valid_o=1 and ready_i=0.
REQ-025 aud_en=0 in any state SHALL force IDLE next cycle: clear sc, oc, si, the partial word, valid_o and overrun_o; data_o holds its last value.
REQ-026 Latency: pin edge to pwm_s SHALL be SYNC_STAGES cycles; last slot sample to valid_o SHALL be 1 cycle after the sc==255, si==3 cycle.

Reset
REQ-027 While rst=1, SHALL force: state IDLE; sc, oc, si, partial word = 0; data_o=32'h0; valid_o=0; sync_err_o=0; overrun_o=0; all synchronizer flops = 0.
REQ-028 rst SHALL take priority over aud_en; a mid-word reset SHALL discard all partial data, and no word SHALL be emitted for the interrupted frame.

Verification
REQ-029 Encoder-shaped stream of samples 8'h00, 8'h7F, 8'hFF, 8'h10 (duty+1 high clocks per slot), ready_i=1 -> valid_o one cycle with data_o=32'h007FFF10, sync_err_o never pulsed.
REQ-030 Two back-to-back words 32'h01020304 then 32'hFEFDFCFB with ready_i=0 throughout -> data_o=32'h01020304 held, overrun_o=1 after the second word completes.
REQ-031 Extra rise injected at sc=100 of slot 2 -> one sync_err_o pulse, partial word discarded, next four slots decode correctly from the new alignment.
REQ-032 pwm_i held low for 600 clocks after lock -> sync_err_o pulse at the first sc==255 with total 0, state HUNT, no valid_o.
REQ-033 aud_en dropped mid-slot 1 with valid_o=1 -> next cycle valid_o=0, overrun_o=0, IDLE; re-enable plus a new stream decodes correctly.
REQ-034 rst asserted at sc=128 of slot 3 -> all outputs zero, and no word is emitted for the interrupted frame.
